// File: rtl/rf_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
// Shared constants, types and helpers for the multi-port register file and
// its scoreboard.
//   XLEN_DEF / AW_DEF : default data and register-address widths
//   reg_addr_t        : architectural register address
//   wr_match_t        : result of a write-port match (hit flag + winning port)
//   onehot_last_match : finds the highest-index enabled write port whose
//                       address equals a given register address
// ----------------------------------------------------------------------------
package rf_pkg;

    localparam int unsigned XLEN_DEF = 64;
    localparam int unsigned AW_DEF   = 5;

    // Fixed-size container for the match helper; callers zero-extend their
    // write-port vectors into it so one function serves every configuration.
    localparam int unsigned MAX_WR = 8;
    localparam int unsigned MAX_AW = 8;
    localparam int unsigned WIDX_W = 3;

    typedef logic [AW_DEF-1:0] reg_addr_t;

    typedef struct packed {
        logic              hit;
        logic [WIDX_W-1:0] idx;
    } wr_match_t;

    // Later ports overwrite earlier hits, so the highest index wins.
    function automatic wr_match_t onehot_last_match(
        input logic [MAX_AW-1:0]        addr,
        input logic [MAX_WR*MAX_AW-1:0] waddr_vec,
        input logic [MAX_WR-1:0]        wen_vec
    );
        wr_match_t m;
        m.hit = 1'b0;
        m.idx = '0;
        for (int k = 0; k < MAX_WR; k++) begin
            if (wen_vec[k] && (waddr_vec[k*MAX_AW +: MAX_AW] == addr)) begin
                m.hit = 1'b1;
                m.idx = WIDX_W'(k);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/rf_sb_bits.sv
// ----------------------------------------------------------------------------
// rf_sb_bits
// Per-register busy-bit array. Priority at each clock edge:
// reset > flush > writeback clear < issue set (issue beats a same-cycle clear).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_flush         : clear every busy bit, drop same-cycle issue
//   i_wen, i_waddr  : writeback ports; each enabled port clears its register
//   i_issue_valid   : an instruction writing i_issue_rd was issued
//   i_issue_rd      : destination register of the issued instruction
//   o_busy          : current busy bits, one per register (bit 0 always 0)
// ----------------------------------------------------------------------------
module rf_sb_bits
    import rf_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned NWR  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic [NWR-1:0]    i_wen,
    input  logic [NWR*AW-1:0] i_waddr,
    input  logic            i_issue_valid,
    input  logic [AW-1:0]   i_issue_rd,
    output logic [NREG-1:0] o_busy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_d;

    always_comb begin
        w_busy_d = r_busy;
        if (i_flush) begin
            w_busy_d = '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (i_wen[k]) begin
                    w_busy_d[i_waddr[k*AW +: AW]] = 1'b0;
                end
            end
            // Applied after the clears: the new producer supersedes the old one.
            if (i_issue_valid && (i_issue_rd != '0)) begin
                w_busy_d[i_issue_rd] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/rf_scoreboard_mp.sv
// ----------------------------------------------------------------------------
// rf_scoreboard_mp
// Parametrised multi-port integer register file with optional same-cycle
// write-to-read bypass and a per-register busy scoreboard.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_wen/i_waddr/i_wdata : NWR packed write ports (port k at [k*W +: W])
//   i_ren/i_raddr       : NRD packed read ports
//   o_rdata             : combinational read data (0 for x0/disabled/reset)
//   o_rbusy             : busy flag of each read address
//   i_issue_valid/i_issue_rd : decode issue, marks destination busy
//   i_flush             : pipeline redirect, clears every busy bit
//   i_dbg_addr/o_dbg_data : debug read of stored contents, never bypassed
// ----------------------------------------------------------------------------
module rf_scoreboard_mp
    import rf_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      i_wen,
    input  logic [NWR*AW-1:0]   i_waddr,
    input  logic [NWR*XLEN-1:0] i_wdata,
    input  logic [NRD-1:0]      i_ren,
    input  logic [NRD*AW-1:0]   i_raddr,
    output logic [NRD*XLEN-1:0] o_rdata,
    output logic [NRD-1:0]      o_rbusy,
    input  logic                i_issue_valid,
    input  logic [AW-1:0]       i_issue_rd,
    input  logic                i_flush,
    input  logic [AW-1:0]       i_dbg_addr,
    output logic [XLEN-1:0]     o_dbg_data
);

    logic [XLEN-1:0]          r_regs [NREG];
    logic [NREG-1:0]          w_busy;
    logic [MAX_WR*MAX_AW-1:0] w_wvec;
    logic [MAX_WR-1:0]        w_wen_ext;
    logic [AW-1:0]            w_ra    [NRD];
    wr_match_t                w_match [NRD];

    rf_sb_bits #(
        .NREG (NREG),
        .AW   (AW),
        .NWR  (NWR)
    ) u_sb_bits (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (i_flush),
        .i_wen         (i_wen),
        .i_waddr       (i_waddr),
        .i_issue_valid (i_issue_valid),
        .i_issue_rd    (i_issue_rd),
        .o_busy        (w_busy)
    );

    // Storage: ascending port order, so the highest-index port wins a conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (i_wen[k] && (i_waddr[k*AW +: AW] != '0)) begin
                    r_regs[i_waddr[k*AW +: AW]] <= i_wdata[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Widen the write ports into the helper's fixed-size layout.
    always_comb begin
        w_wvec    = '0;
        w_wen_ext = '0;
        for (int k = 0; k < NWR; k++) begin
            w_wvec[k*MAX_AW +: MAX_AW] = MAX_AW'(i_waddr[k*AW +: AW]);
            w_wen_ext[k]               = i_wen[k];
        end
    end

    // One match result per read port feeds both the data mux and busy masking.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            w_ra[i]    = i_raddr[i*AW +: AW];
            w_match[i] = onehot_last_match(MAX_AW'(w_ra[i]), w_wvec, w_wen_ext);
        end
    end

    always_comb begin
        o_rdata = '0;
        o_rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (!rst && i_ren[i] && (w_ra[i] != '0)) begin
                if ((BYPASS != 0) && w_match[i].hit) begin
                    o_rdata[i*XLEN +: XLEN] = i_wdata[int'(w_match[i].idx)*XLEN +: XLEN];
                    o_rbusy[i]              = 1'b0;
                end else begin
                    o_rdata[i*XLEN +: XLEN] = r_regs[w_ra[i]];
                    o_rbusy[i]              = w_busy[w_ra[i]];
                end
            end
        end
    end

    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: tb/tb_rf_scoreboard_mp.sv
// ----------------------------------------------------------------------------
// tb_rf_scoreboard_mp
// Drives a BYPASS=1 and a BYPASS=0 instance with identical stimulus. Each
// cycle the expected outputs (from a reference model of registers and busy
// bits) are queued when the inputs are applied and compared at the falling
// edge, before the model is advanced past the next rising edge.
// ----------------------------------------------------------------------------
module tb_rf_scoreboard_mp;
    import rf_pkg::*;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NRD  = 2;
    localparam int unsigned NWR  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NWR-1:0]      wen;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NRD-1:0]      ren;
    logic [NRD*AW-1:0]   raddr;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                flush;
    logic [AW-1:0]       dbg_addr;
    logic [NRD*XLEN-1:0] rdata_b, rdata_n;
    logic [NRD-1:0]      rbusy_b, rbusy_n;
    logic [XLEN-1:0]     dbg_b, dbg_n;

    always #5 clk = ~clk;

    rf_scoreboard_mp #(
        .XLEN (XLEN), .NREG (NREG), .AW (AW), .NRD (NRD), .NWR (NWR), .BYPASS (1)
    ) u_dut_byp (
        .clk           (clk),
        .rst           (rst),
        .i_wen         (wen),
        .i_waddr       (waddr),
        .i_wdata       (wdata),
        .i_ren         (ren),
        .i_raddr       (raddr),
        .o_rdata       (rdata_b),
        .o_rbusy       (rbusy_b),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .i_flush       (flush),
        .i_dbg_addr    (dbg_addr),
        .o_dbg_data    (dbg_b)
    );

    rf_scoreboard_mp #(
        .XLEN (XLEN), .NREG (NREG), .AW (AW), .NRD (NRD), .NWR (NWR), .BYPASS (0)
    ) u_dut_nb (
        .clk           (clk),
        .rst           (rst),
        .i_wen         (wen),
        .i_waddr       (waddr),
        .i_wdata       (wdata),
        .i_ren         (ren),
        .i_raddr       (raddr),
        .o_rdata       (rdata_n),
        .o_rbusy       (rbusy_n),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .i_flush       (flush),
        .i_dbg_addr    (dbg_addr),
        .o_dbg_data    (dbg_n)
    );

    typedef struct packed {
        logic [63:0] rd_b0;
        logic [63:0] rd_b1;
        logic [63:0] rd_n0;
        logic [63:0] rd_n1;
        logic [1:0]  rb_b;
        logic [1:0]  rb_n;
        logic [63:0] dbg;
        logic        chk_dbg;
    } exp_t;

    exp_t        q[$];
    string       tq[$];
    exp_t        mon_e;
    string       mon_tag;
    logic [63:0] m_regs [NREG];
    bit          m_busy [NREG];
    bit          m_known = 1'b0;
    int unsigned n_chk   = 0;
    int unsigned n_pass  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Expected read of one port given the currently driven inputs and model state.
    function automatic void exp_rd(input bit byp, input logic en, input reg_addr_t a,
                                   output logic [63:0] d, output logic b);
        logic        hit;
        logic [63:0] wd;
        d   = '0;
        b   = 1'b0;
        hit = 1'b0;
        wd  = '0;
        if (!rst && en && (a != 0)) begin
            if (wen[1] && (waddr[9:5] == a)) begin
                hit = 1'b1;
                wd  = wdata[127:64];
            end else if (wen[0] && (waddr[4:0] == a)) begin
                hit = 1'b1;
                wd  = wdata[63:0];
            end
            if (byp && hit) begin
                d = wd;
            end else begin
                d = m_regs[a];
                b = m_busy[a];
            end
        end
    endfunction

    task automatic cyc(input string tag, input logic rs, input logic [1:0] we,
                       input reg_addr_t a0, input logic [63:0] d0,
                       input reg_addr_t a1, input logic [63:0] d1,
                       input logic [1:0] re, input reg_addr_t r0, input reg_addr_t r1,
                       input logic iv, input reg_addr_t ird, input logic fl,
                       input reg_addr_t dbg);
        exp_t e;
        logic b;
        rst         = rs;
        wen         = we;
        waddr       = {a1, a0};
        wdata       = {d1, d0};
        ren         = re;
        raddr       = {r1, r0};
        issue_valid = iv;
        issue_rd    = ird;
        flush       = fl;
        dbg_addr    = dbg;
        e = '0;
        exp_rd(1'b1, re[0], r0, e.rd_b0, b); e.rb_b[0] = b;
        exp_rd(1'b1, re[1], r1, e.rd_b1, b); e.rb_b[1] = b;
        exp_rd(1'b0, re[0], r0, e.rd_n0, b); e.rb_n[0] = b;
        exp_rd(1'b0, re[1], r1, e.rd_n1, b); e.rb_n[1] = b;
        e.dbg     = (dbg == 0) ? 64'd0 : m_regs[dbg];
        e.chk_dbg = m_known;
        q.push_back(e);
        tq.push_back(tag);
        @(posedge clk);
        if (rs) begin
            for (int i = 0; i < NREG; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_known = 1'b1;
        end else begin
            if (we[0] && (a0 != 0)) m_regs[a0] = d0;
            if (we[1] && (a1 != 0)) m_regs[a1] = d1;
            if (fl) begin
                for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            end else begin
                if (we[0]) m_busy[a0] = 1'b0;
                if (we[1]) m_busy[a1] = 1'b0;
                if (iv && (ird != 0)) m_busy[ird] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic rd(input string tag, input reg_addr_t r0, input reg_addr_t r1,
                      input reg_addr_t dbg);
        cyc(tag, 1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b11, r0, r1, 1'b0, 5'd0, 1'b0, dbg);
    endtask

    task automatic iss(input string tag, input reg_addr_t ird, input reg_addr_t r0);
        cyc(tag, 1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b11, r0, 5'd0, 1'b1, ird, 1'b0, r0);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e   = q.pop_front();
            mon_tag = tq.pop_front();
            chk({mon_tag, ".byp.rd0"}, rdata_b[63:0],   mon_e.rd_b0);
            chk({mon_tag, ".byp.rd1"}, rdata_b[127:64], mon_e.rd_b1);
            chk({mon_tag, ".nb.rd0"},  rdata_n[63:0],   mon_e.rd_n0);
            chk({mon_tag, ".nb.rd1"},  rdata_n[127:64], mon_e.rd_n1);
            chk({mon_tag, ".byp.busy"}, {62'd0, rbusy_b}, {62'd0, mon_e.rb_b});
            chk({mon_tag, ".nb.busy"},  {62'd0, rbusy_n}, {62'd0, mon_e.rb_n});
            if (mon_e.chk_dbg) begin
                chk({mon_tag, ".byp.dbg"}, dbg_b, mon_e.dbg);
                chk({mon_tag, ".nb.dbg"},  dbg_n, mon_e.dbg);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reg_addr_t   ra0, ra1, wa0, wa1, ird, dbg;
        logic [1:0]  we, re;
        logic        rs, fl, iv;
        rst = 1'b1; wen = '0; waddr = '0; wdata = '0; ren = '0; raddr = '0;
        issue_valid = 1'b0; issue_rd = '0; flush = 1'b0; dbg_addr = '0;
        @(posedge clk);
        #1;

        // Reset for two cycles, reads forced to zero during reset.
        cyc("rst0", 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b11, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd1);
        cyc("rst1", 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b11, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 5'd2);
        for (int i = 0; i < NREG; i++) begin
            rd("zero", reg_addr_t'(i), reg_addr_t'(NREG - 1 - i), reg_addr_t'(i));
        end

        // x0 is hardwired to zero and never busy.
        cyc("wx0", 1'b0, 2'b01, 5'd0, 64'hDEAD, 5'd0, 64'd0, 2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
        rd("rx0", 5'd0, 5'd0, 5'd0);

        // Same-cycle bypass vs. next-cycle visibility.
        cyc("byp5", 1'b0, 2'b01, 5'd5, 64'h1234, 5'd0, 64'd0, 2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5);
        rd("rd5", 5'd5, 5'd5, 5'd5);

        // Write-port conflict: highest port wins, both for storage and bypass.
        cyc("cf7", 1'b0, 2'b11, 5'd7, 64'hAA, 5'd7, 64'hBB, 2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 5'd7);
        rd("rd7", 5'd7, 5'd7, 5'd7);

        // Scoreboard life cycle on x10.
        iss("iss10", 5'd10, 5'd10);
        rd("bsy10", 5'd10, 5'd10, 5'd10);
        cyc("wb10", 1'b0, 2'b01, 5'd10, 64'h55, 5'd0, 64'd0, 2'b11, 5'd10, 5'd10, 1'b0, 5'd0, 1'b0, 5'd10);
        rd("clr10", 5'd10, 5'd10, 5'd10);

        // Issue and writeback to the same register in one cycle: stays busy.
        iss("iss3", 5'd3, 5'd3);
        cyc("col3", 1'b0, 2'b01, 5'd3, 64'h33, 5'd0, 64'd0, 2'b11, 5'd3, 5'd3, 1'b1, 5'd3, 1'b0, 5'd3);
        rd("bsy3", 5'd3, 5'd3, 5'd3);

        // Flush clears all busy bits and drops a same-cycle issue.
        iss("iss4", 5'd4, 5'd4);
        iss("iss5", 5'd5, 5'd4);
        iss("iss6", 5'd6, 5'd5);
        cyc("fl8", 1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 2'b11, 5'd4, 5'd5, 1'b1, 5'd8, 1'b1, 5'd6);
        rd("afl_a", 5'd4, 5'd8, 5'd4);
        rd("afl_b", 5'd5, 5'd6, 5'd8);

        // Mid-flight reset with writes and issue active.
        iss("iss4b", 5'd4, 5'd4);
        iss("iss9", 5'd9, 5'd4);
        cyc("rstmid", 1'b1, 2'b11, 5'd9, 64'h99, 5'd12, 64'h77, 2'b11, 5'd5, 5'd7, 1'b1, 5'd11, 1'b0, 5'd5);
        rd("arst_a", 5'd9, 5'd4, 5'd9);
        rd("arst_b", 5'd5, 5'd7, 5'd7);
        rd("arst_c", 5'd12, 5'd11, 5'd12);

        // Random traffic, biased to a few registers to provoke conflicts.
        for (int n = 0; n < 400; n++) begin
            rs  = ($urandom_range(0, 79) == 0);
            fl  = ($urandom_range(0, 15) == 0);
            iv  = $urandom_range(0, 1) == 1;
            we  = 2'($urandom_range(0, 3));
            re  = 2'($urandom_range(0, 3));
            wa0 = reg_addr_t'($urandom_range(0, 7));
            wa1 = reg_addr_t'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            ra0 = reg_addr_t'($urandom_range(0, 7));
            ra1 = reg_addr_t'($urandom_range(0, 31));
            ird = reg_addr_t'($urandom_range(0, 7));
            dbg = reg_addr_t'($urandom_range(0, 31));
            cyc("rnd", rs, we, wa0, {$urandom, $urandom}, wa1, {$urandom, $urandom},
                re, ra0, ra1, iv, ird, fl, dbg);
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard_mp.md
Name: rf_scoreboard_mp

Overview:
- Parametrised multi-port integer register file for the pipelined core; replaces the single-cycle 2R/1W regfile.
- Adds configurable read/write port counts and optional same-cycle write-to-read bypass.
- Adds a per-register scoreboard (busy bits): decode sets a bit at issue, writeback clears it, and the flush input clears all bits on redirect.
- Sits between decode/issue (read, issue ports) and writeback (write ports).

Parameters:
- XLEN, 64, data width of each register.
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.
- AW, 5, address width; must equal clog2(NREG).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = write visible the cycle after.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wen  in  NWR  per-port write enable.
- waddr  in  NWR*AW  packed write addresses; port k occupies bits [k*AW +: AW].
- wdata  in  NWR*XLEN  packed write data.
- ren  in  NRD  per-port read enable.
- raddr  in  NRD*AW  packed read addresses.
- rdata  out  NRD*XLEN  packed read data.
- rbusy  out  NRD  scoreboard busy flag for each read address.
- issue_valid  in  1  decode issues an instruction that writes issue_rd.
- issue_rd  in  AW  destination register of the issued instruction.
- flush  in  1  pipeline redirect; clears all busy bits.
- dbg_addr  in  AW  debug/difftest read address.
- dbg_data  out  XLEN  debug read data; never bypassed.

Behaviour:
- Storage: NREG x XLEN flops plus NREG busy bits.
- rst high at a clock edge:
  - all registers become 0 and all busy bits become 0;
  - all wen, issue_valid and flush inputs are ignored that cycle.
- While rst is high:
  - rdata = 0 and rbusy = 0, combinationally;
  - dbg_data still returns stored contents, which are 0 from the cycle after the first reset edge.
- Write: at posedge, for each port k with wen[k] = 1 and waddr[k] != 0, regs[waddr[k]] <= wdata[k].
- Write conflict: if two enabled ports target the same address, the highest-index port wins, deterministically.
- Register 0: writes are dropped, reads return 0, and it is never busy.
- Read, port i:
  - rdata[i] = 0 if ren[i] = 0, raddr[i] = 0, or rst = 1.
  - Otherwise, if BYPASS = 1 and some enabled write port targets raddr[i] this cycle, return that port's wdata (highest index wins).
  - Otherwise return regs[raddr[i]].
  - Purely combinational; zero-cycle read latency.
- Scoreboard, evaluated at posedge in this priority order:
  1. rst clears all bits.
  2. flush clears all bits, and any issue_valid in the same cycle is ignored.
  3. Writeback clears busy[waddr[k]] for each enabled port.
  4. issue_valid with issue_rd != 0 sets busy[issue_rd]. Issue wins over a writeback clear to the same register in the same cycle, because the new producer supersedes the old one.
- rbusy:
  - rbusy[i] = busy[raddr[i]] & ren[i] & (raddr[i] != 0).
  - If BYPASS = 1, rbusy[i] is additionally masked to 0 when an enabled write port targets raddr[i] in this cycle, because the data is forwarded.
  - If BYPASS = 0, no masking is applied.
- Issuing to a register that is already busy: it stays busy. Only one outstanding producer per register is tracked; the next writeback clears it.
- Mid-operation reset: pending busy bits and data are discarded. No residual state remains.
- dbg_data = regs[dbg_addr], with register 0 returning 0.
- No outputs are registered; all storage updates occur only at posedge clk.

Decomposition:
- Shared package rf_pkg:
  - XLEN and AW default constants;
  - reg-address typedef;
  - helper function onehot_last_match(addr, waddr_vec, wen_vec), returning the winning write-port index and a hit flag.
- The bypass/priority resolution helper is used by both the read mux and the busy masking.
- One natural sub-module: rf_sb_bits, the NREG-entry busy-bit array with its set/clear/flush priority logic. Storage and read muxing stay in the top.

Test Plan:
- Reset and zero register: assert rst 2 cycles, then read all regs on ports 0 and 1 -> rdata = 0. Write x0 = 0xDEAD -> a subsequent read of x0 = 0 and rbusy = 0.
- Write and bypass: with BYPASS = 1, set wen[0] = 1, waddr = 5, wdata = 0x1234, and raddr[0] = 5 in the same cycle -> rdata = 0x1234 that cycle. With BYPASS = 0, the same stimulus gives the old value (0), then 0x1234 on the next cycle.
- Write-port conflict: both ports write x7 (port 0 = 0xAA, port 1 = 0xBB) -> x7 = 0xBB afterwards, and the bypassed read that cycle returns 0xBB.
- Scoreboard life cycle: issue x10 -> rbusy = 1 on the next cycle. Writeback x10 = 0x55 -> with BYPASS = 1, rbusy = 0 and rdata = 0x55 in the writeback cycle; the busy bit is clear from the next cycle.
- Issue/writeback collision: x3 is busy; in the same cycle, writeback x3 and issue x3 -> x3 remains busy the next cycle, and data is updated.
- Flush and reset mid-flight: issue x4, x5, x6 on successive cycles, then flush together with issue x8 -> all busy = 0 and x8 is not busy. Repeat with rst instead of flush while wen is active -> the write is dropped and all regs = 0.
